// File: rtl/sadiv_seq.sv
// ----------------------------------------------------------------------------
// sadiv_seq : 32-bit signed sequential divider (restoring, one bit per cycle)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sadiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [4:0]  cnt;
  logic [31:0] qreg;
  logic [31:0] dvs;
  logic [31:0] prem;
  logic        neg_q;
  logic        neg_r;
  logic        b_zero;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // The restored remainder is always below the divisor, so 32 bits hold it;
  // only the trial subtraction needs the 33rd bit.
  assign shifted = {prem, qreg[31]};
  assign diff    = shifted - {1'b0, dvs};

  // A zero divisor leaves |a| as remainder, so the sign fix-up returns a itself.
  assign q_fix = b_zero ? 32'hFFFF_FFFF : (neg_q ? (~qreg + 32'd1) : qreg);
  assign r_fix = neg_r ? (~prem + 32'd1) : prem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 5'd0;
      qreg        <= 32'd0;
      dvs         <= 32'd0;
      prem        <= 32'd0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_zero      <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            qreg   <= a[31] ? (~a + 32'd1) : a;
            dvs    <= b[31] ? (~b + 32'd1) : b;
            prem   <= 32'd0;
            cnt    <= 5'd0;
            neg_q  <= a[31] ^ b[31];
            neg_r  <= a[31];
            b_zero <= (b == 32'd0);
          end
        end
        CALC: begin
          cnt  <= cnt + 5'd1;
          prem <= diff[32] ? shifted[31:0] : diff[31:0];
          qreg <= {qreg[30:0], ~diff[32]};
        end
        FIX: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= b_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sadiv_seq.sv
// ----------------------------------------------------------------------------
// tb_sadiv_seq : scoreboard bench for sadiv_seq against an arithmetic model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sadiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          e0;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  sadiv_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Plain signed arithmetic: '/' and '%' truncate toward zero, remainder
  // takes the dividend's sign; 64-bit operands avoid the -2^31/-1 overflow.
  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_v);
    exp_t   e;
    longint sa;
    longint sb;
    sa = longint'($signed(ta));
    sb = longint'($signed(tb_v));
    e.a = ta;
    e.b = tb_v;
    e.e0 = 0;
    if (sb == 0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = ta;
      e.z = 1'b1;
    end else begin
      e.q = 32'(sa / sb);
      e.r = 32'(sa % sb);
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Counting E0 as the first edge, done appears after the 34th, i.e. 33 edges later.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending result", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("quotient a=%h b=%h", e.a, e.b), quotient, e.q);
        check($sformatf("remainder a=%h b=%h", e.a, e.b), remainder, e.r);
        check($sformatf("div_by_zero a=%h b=%h", e.a, e.b), {31'd0, div_by_zero}, {31'd0, e.z});
        check("done_latency", 32'(cyc - e.e0), 32'd33);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_timeout: got busy=1, expected 0 within 100 cycles");
    end
  endtask

  task automatic push_accepted(input logic [31:0] ta, input logic [31:0] tb_v);
    exp_t e;
    e = model(ta, tb_v);
    e.e0 = cyc;
    exp_q.push_back(e);
  endtask

  // Drives one start pulse from IDLE and scrambles a/b right after E0.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v);
    wait_idle();
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_accepted(ta, tb_v);
    a = $urandom;
    b = $urandom;
    check("busy_after_E0", {31'd0, busy}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    rst_n = 1'b1;

    issue(32'd100, 32'd7);
    drain();
    issue(32'hFFFF_FF9C, 32'd7);
    issue(32'd100, 32'hFFFF_FFF9);
    issue(32'd5, 32'd0);
    issue(32'd9, 32'd3);
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    issue(32'h8000_0000, 32'd2);
    issue(32'h8000_0000, 32'd0);
    issue(32'h8000_0000, 32'h8000_0000);
    issue(32'd0, 32'hFFFF_FFFF);
    drain();

    // A second start while busy must be dropped entirely.
    issue(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    a = 32'd1;
    b = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    check("ignored_start_idle", {31'd0, busy}, 32'd0);

    // Held start: the next division begins on the first IDLE edge after DONE.
    wait_idle();
    a = 32'd9;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    push_accepted(32'd9, 32'd3);
    a = 32'hFFFF_FFF6;
    b = 32'd4;
    begin
      int n = 0;
      while (!done && n < 60) begin
        @(negedge clk);
        n++;
      end
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    push_accepted(32'hFFFF_FFF6, 32'd4);
    check("held_start_busy", {31'd0, busy}, 32'd1);
    drain();

    // Reset 20 cycles into a division: immediate clear, no done afterwards.
    issue(32'h1234_5678, 32'd3);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'd100, 32'd7);
    drain();

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = ~32'($urandom_range(0, 20)) ;
        3: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      issue(ra, rb);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sadiv_seq.md
SADIV_SEQ -- requirements
Module: sadiv_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit operands.
REQ-002 The block SHALL have the port `clk  input  1`: single clock, all state on its rising edge.
REQ-003 The block SHALL have the port `rst_n  input  1`: asynchronous, active-low reset.
REQ-004 The block SHALL have the port `start  input  1`: request a division, sampled only in IDLE.
REQ-005 The block SHALL have the port `a  input  32`: signed two's-complement dividend, captured with start.
REQ-006 The block SHALL have the port `b  input  32`: signed two's-complement divisor, captured with start.
REQ-007 The block SHALL have the port `busy  output  1`: high from the cycle after start is accepted until done drops.
REQ-008 The block SHALL have the port `done  output  1`: one-cycle pulse marking valid quotient/remainder.
REQ-009 The block SHALL have the port `quotient  output  32`: signed quotient, truncated toward zero.
REQ-010 The block SHALL have the port `remainder  output  32`: signed remainder, sign of dividend.
REQ-011 The block SHALL have the port `div_by_zero  output  1`: high with the result when b was 0.

Function
REQ-012 The block SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-013 IDLE SHALL go to CALC when start=1.
REQ-014 CALC SHALL run for exactly 32 cycles, then go to FIX.
REQ-015 FIX SHALL go to DONE.
REQ-016 DONE SHALL go to IDLE.
REQ-017 At the accepting edge (E0), the block SHALL latch |a| and |b| as 32-bit unsigned magnitudes, the signs a[31] and b[31], and a zero flag (b==0).
REQ-018 CALC SHALL perform one restoring shift-subtract iteration per cycle on a 33-bit partial remainder, MSB of the dividend first, with an iteration counter counting 0..31.
REQ-019 FIX SHALL negate the quotient if a[31]^b[31], SHALL negate the remainder if a[31], and SHALL register quotient, remainder and div_by_zero.
REQ-020 done SHALL be 1 only in DONE, i.e. high for exactly one cycle, following the 34th rising edge after E0.
REQ-021 busy SHALL be 1 in CALC, FIX and DONE, and 0 in IDLE.
REQ-022 quotient, remainder and div_by_zero SHALL update only on entry to DONE, then hold until the next DONE or reset.
REQ-023 start asserted while busy=1 SHALL be ignored, with no queueing.
REQ-024 Operands SHALL be latched only at E0; a and b changes afterward SHALL have no effect.
REQ-025 When b=0, the block SHALL output quotient=0xFFFFFFFF, remainder=a and div_by_zero=1, with the same 34-cycle latency.
REQ-026 When a=0x80000000 and b=0xFFFFFFFF, the block SHALL output quotient=0x80000000, remainder=0 and div_by_zero=0, with no trap.
REQ-027 When a=0x80000000 with any other divisor, the magnitude SHALL be computed as the unsigned value 2^31, and the results SHALL be exact.
REQ-028 For every b≠0, the outputs SHALL satisfy a = quotient*b + remainder (mod 2^32), with |remainder| < |b|.
REQ-029 start held high continuously SHALL begin a new division on the first IDLE cycle after DONE.
REQ-030 The block SHALL have no combinational path from inputs to outputs.

Reset
REQ-031 rst_n=0 SHALL force, asynchronously, state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, and all internal registers to 0.
REQ-032 Reset asserted mid-CALC or mid-FIX SHALL abort the operation, and no done pulse SHALL follow.
REQ-033 After rst_n deassertion, the first start SHALL be accepted on the first rising edge at which rst_n=1 and start=1.

Verification
REQ-034 The bench SHALL cover: a=100, b=7, start pulse -> done exactly 34 cycles after E0, quotient=14, remainder=2, div_by_zero=0.
REQ-035 The bench SHALL cover: a=-100 (0xFFFFFF9C), b=7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); and a=100, b=-7 -> quotient=-14, remainder=2.
REQ-036 The bench SHALL cover: a=5, b=0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1 with done; the next division (a=9, b=3) -> quotient=3, remainder=0, div_by_zero=0.
REQ-037 The bench SHALL cover: a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0; and a=0x80000000, b=2 -> quotient=0xC0000000, remainder=0.
REQ-038 The bench SHALL cover: start for a=100, b=7, then at cycle 10 start with a=1, b=1 -> ignored, a single done, quotient=14, remainder=2.
REQ-039 The bench SHALL cover: rst_n pulled low at cycle 20 of a division -> busy=0 immediately, outputs 0, no done; a new start after release returns a correct result.
